// File: rtl/banked_mem.sv
// Banked wide-read memory: byte-strobed host writes, full-row reads, built-in clear engine.
// Optional BANKED_MEM_OUTREG_EN adds an output pipeline stage on rdata/rvalid (read latency 2).
module banked_mem #(
  parameter int unsigned NBANK = 8,
  parameter int unsigned BW    = 16,
  parameter int unsigned WW    = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH * NBANK * BW / 8)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clr,
  output logic                       busy,
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [AW-1:0]              waddr,
  input  logic [WW/8-1:0]            wstrb,
  input  logic [WW-1:0]              wdata,
  input  logic                       rreq,
  input  logic [$clog2(DEPTH)-1:0]   rrow,
  output logic                       rvalid,
  output logic [NBANK*BW-1:0]        rdata
);

  localparam int unsigned RW    = $clog2(DEPTH);
  localparam int unsigned LANES = WW / BW;
  localparam int unsigned BPB   = BW / 8;
  localparam int unsigned G     = NBANK * BW / WW;
  localparam int unsigned GW    = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned WDW   = AW - 2;
  localparam int unsigned DW    = NBANK * BW;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   cnt, cnt_nxt;
  logic            clear_en_c, wr_fire_c, rd_fire_c;
  logic [WDW-1:0]  wword;
  logic [GW-1:0]   wgroup;
  logic [RW-1:0]   wrow;
  logic [DW-1:0]   row_q;
  logic            rv1;
  logic            unused_waddr;

  // Word-aligned address split into bank group and row.
  assign wword        = waddr[AW-1:2];
  assign wgroup       = GW'(32'(wword) % G);
  assign wrow         = RW'(32'(wword) / G);
  assign unused_waddr = ^waddr[1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (clr) state_nxt = S_CLEAR;
      S_CLEAR: if (!clr && (cnt == RW'(DEPTH - 1))) state_nxt = S_IDLE;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Output / datapath control; clr during a clear restarts the row counter.
  always_comb begin
    clear_en_c = 1'b0;
    wr_fire_c  = 1'b0;
    rd_fire_c  = 1'b0;
    cnt_nxt    = cnt;
    case (state)
      S_IDLE: begin
        wr_fire_c = wvalid;
        rd_fire_c = rreq;
        if (clr) cnt_nxt = '0;
      end
      S_CLEAR: begin
        clear_en_c = 1'b1;
        cnt_nxt    = clr ? '0 : cnt + RW'(1);
      end
      default: ;
    endcase
  end

  // Counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt    <= '0;
      busy   <= 1'b1;
      wready <= 1'b0;
      rv1    <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      busy   <= (state_nxt == S_CLEAR);
      wready <= (state_nxt == S_IDLE);
      rv1    <= rd_fire_c;
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    localparam int unsigned LANE = b % LANES;
    localparam int unsigned GRP  = b / LANES;

    logic [BW-1:0] mem [DEPTH];
    logic [BW-1:0] bmask;
    logic [BW-1:0] wlane;
    logic [BW-1:0] rq;
    logic          we;

    for (genvar j = 0; j < BPB; j++) begin : g_byte
      assign bmask[j*8 +: 8] = {8{wstrb[LANE*BPB + j]}};
    end

    assign wlane = wdata[LANE*BW +: BW];
    assign we    = wr_fire_c && (wgroup == GW'(GRP));

    // Clear engine and host writes never overlap: writes only fire in IDLE.
    always_ff @(posedge clk) begin
      if (clear_en_c) begin
        mem[cnt] <= '0;
      end else if (we) begin
        mem[wrow] <= (mem[wrow] & ~bmask) | (wlane & bmask);
      end
    end

    // Read-first: a same-cycle write to this row lands after the sample.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        rq <= '0;
      end else if (rd_fire_c) begin
        rq <= mem[rrow];
      end
    end

    assign row_q[b*BW +: BW] = rq;
  end

`ifdef BANKED_MEM_OUTREG_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rdata  <= row_q;
      rvalid <= rv1;
    end
  end
`else
  assign rdata  = row_q;
  assign rvalid = rv1;
`endif

endmodule
